// File: rtl/if_fetch_ctrl.sv
// Instruction-fetch sequencer: fetch PC, imem req/ready handshake, one-entry skid, IF/ID register.
// Latency 1 cycle im_rdata->if_instr; stall parks a returned word in the skid (HOLD, no request).
// Optional macro IF_DELAY_SLOT_EN keeps the in-flight/skid instruction on redirect (MIPS delay slot).
module if_fetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        redir_valid,
    input  logic [31:0] redir_pc,
    output logic        im_req,
    output logic [31:0] im_addr,
    input  logic        im_ready,
    input  logic [31:0] im_rdata,
    output logic        if_valid,
    output logic [31:0] if_pc,
    output logic [31:0] if_instr
);

    typedef enum logic [1:0] {IDLE, FETCH, HOLD} state_t;

    state_t      state, state_nxt;
    logic [31:0] pc, pc_nxt;
    logic        pend, pend_nxt;
    logic [31:0] pend_pc, pend_pc_nxt;
    logic        squash, squash_nxt;
    logic [31:0] skid_pc, skid_pc_nxt;
    logic [31:0] skid_instr, skid_instr_nxt;
    logic        ifid_vld_nxt;
    logic [31:0] ifid_pc_nxt, ifid_instr_nxt;
    logic [31:0] next_pc;

    // Freshest redirect wins over a latched one; otherwise sequential.
    assign next_pc = redir_valid ? redir_pc : (pend ? pend_pc : pc + 32'd4);
    assign im_addr = pc;

    always_comb begin
        state_nxt      = state;
        pc_nxt         = pc;
        pend_nxt       = pend;
        pend_pc_nxt    = pend_pc;
        squash_nxt     = squash;
        skid_pc_nxt    = skid_pc;
        skid_instr_nxt = skid_instr;
        ifid_vld_nxt   = stall ? if_valid : 1'b0;
        ifid_pc_nxt    = if_pc;
        ifid_instr_nxt = if_instr;
        im_req         = 1'b0;

        if (redir_valid) begin
            pend_nxt    = 1'b1;
            pend_pc_nxt = redir_pc;
        end

        case (state)
            IDLE: begin
                state_nxt = FETCH;
`ifndef IF_DELAY_SLOT_EN
                // Nothing in flight to squash: steer the first fetch directly.
                if (redir_valid) begin
                    pc_nxt   = redir_pc;
                    pend_nxt = 1'b0;
                end
`endif
            end
            FETCH: begin
                im_req = 1'b1;
                if (im_ready) begin
`ifndef IF_DELAY_SLOT_EN
                    if (redir_valid || squash) begin
                        pc_nxt     = redir_valid ? redir_pc : pend_pc;
                        pend_nxt   = 1'b0;
                        squash_nxt = 1'b0;
                    end else
`endif
                    if (!stall) begin
                        ifid_vld_nxt   = 1'b1;
                        ifid_pc_nxt    = pc;
                        ifid_instr_nxt = im_rdata;
                        pc_nxt         = next_pc;
                        pend_nxt       = 1'b0;
                    end else begin
                        skid_pc_nxt    = pc;
                        skid_instr_nxt = im_rdata;
                        state_nxt      = HOLD;
                    end
                end else begin
`ifndef IF_DELAY_SLOT_EN
                    if (redir_valid) squash_nxt = 1'b1;
`endif
                end
            end
            HOLD: begin
`ifndef IF_DELAY_SLOT_EN
                if (redir_valid) begin
                    pc_nxt    = redir_pc;
                    pend_nxt  = 1'b0;
                    state_nxt = FETCH;
                end else
`endif
                if (!stall) begin
                    ifid_vld_nxt   = 1'b1;
                    ifid_pc_nxt    = skid_pc;
                    ifid_instr_nxt = skid_instr;
                    pc_nxt         = next_pc;
                    pend_nxt       = 1'b0;
                    state_nxt      = FETCH;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            pc         <= RESET_PC;
            pend       <= 1'b0;
            pend_pc    <= 32'd0;
            squash     <= 1'b0;
            skid_pc    <= 32'd0;
            skid_instr <= 32'd0;
            if_valid   <= 1'b0;
            if_pc      <= 32'd0;
            if_instr   <= 32'd0;
        end else begin
            state      <= state_nxt;
            pc         <= pc_nxt;
            pend       <= pend_nxt;
            pend_pc    <= pend_pc_nxt;
            squash     <= squash_nxt;
            skid_pc    <= skid_pc_nxt;
            skid_instr <= skid_instr_nxt;
            if_valid   <= ifid_vld_nxt;
            if_pc      <= ifid_pc_nxt;
            if_instr   <= ifid_instr_nxt;
        end
    end

endmodule

// File: tb/tb_if_fetch_ctrl.sv
// Bench for if_fetch_ctrl: directed literal scenarios plus randomized traffic
// checked every cycle against a transaction-level fetch model.
module tb_if_fetch_ctrl;

`ifdef IF_DELAY_SLOT_EN
    localparam bit DS = 1'b1;
`else
    localparam bit DS = 1'b0;
`endif
    localparam logic [31:0] RST_PC = 32'h0000_3000;

    logic        clk = 1'b0;
    logic        reset, stall, redir_valid, im_ready;
    logic [31:0] redir_pc, im_rdata;
    logic        im_req, if_valid;
    logic [31:0] im_addr, if_pc, if_instr;

    int checks = 0;
    int failures = 0;
    bit chk_en = 1'b0;

    // Behavioural model: one outstanding fetch address, an optional parked
    // instruction, an optional remembered redirect target and a doomed flag.
    bit          m_started;
    logic [31:0] m_pc;
    bit          m_tgt_v;
    logic [31:0] m_tgt;
    bit          m_doomed;
    logic [63:0] m_held[$];
    bit          m_v;
    logic [31:0] m_ipc, m_ins;

    if_fetch_ctrl #(.RESET_PC(RST_PC)) dut (
        .clk(clk), .reset(reset), .stall(stall),
        .redir_valid(redir_valid), .redir_pc(redir_pc),
        .im_req(im_req), .im_addr(im_addr),
        .im_ready(im_ready), .im_rdata(im_rdata),
        .if_valid(if_valid), .if_pc(if_pc), .if_instr(if_instr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_update();
        logic [31:0] after;
        if (reset) begin
            m_started = 0; m_pc = RST_PC; m_tgt_v = 0; m_tgt = 0; m_doomed = 0;
            m_held.delete(); m_v = 0; m_ipc = 0; m_ins = 0;
            return;
        end
        after = redir_valid ? redir_pc : (m_tgt_v ? m_tgt : m_pc + 32'd4);
        if (!m_started) begin
            m_started = 1;
            if (redir_valid && !DS) m_pc = redir_pc;
            else if (redir_valid) begin m_tgt_v = 1; m_tgt = redir_pc; end
        end else if (m_held.size() == 0) begin
            if (im_ready) begin
                if (!DS && (redir_valid || m_doomed)) begin
                    m_pc = redir_valid ? redir_pc : m_tgt;
                    m_tgt_v = 0; m_doomed = 0;
                    if (!stall) m_v = 0;
                end else if (!stall) begin
                    m_v = 1; m_ipc = m_pc; m_ins = im_rdata;
                    m_pc = after; m_tgt_v = 0;
                end else begin
                    m_held.push_back({m_pc, im_rdata});
                    if (redir_valid) begin m_tgt_v = 1; m_tgt = redir_pc; end
                end
            end else begin
                if (redir_valid) begin
                    m_tgt_v = 1; m_tgt = redir_pc;
                    if (!DS) m_doomed = 1;
                end
                if (!stall) m_v = 0;
            end
        end else begin
            if (!DS && redir_valid) begin
                m_held.delete(); m_pc = redir_pc;
                if (!stall) m_v = 0;
            end else if (!stall) begin
                {m_ipc, m_ins} = m_held.pop_front();
                m_v = 1; m_pc = after; m_tgt_v = 0;
            end else if (redir_valid) begin
                m_tgt_v = 1; m_tgt = redir_pc;
            end
        end
    endtask

    // Single compare process against the model, away from the active edge.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("im_req", 32'(im_req), 32'(m_started && m_held.size() == 0));
            chk("im_addr", im_addr, m_pc);
            chk("if_valid", 32'(if_valid), 32'(m_v));
            chk("if_pc", if_pc, m_ipc);
            chk("if_instr", if_instr, m_ins);
        end
    end

    task automatic step(input logic rst, input logic st, input logic rv, input logic [31:0] rp,
                        input logic rdy, input logic [31:0] rd);
        reset = rst; stall = st; redir_valid = rv; redir_pc = rp; im_ready = rdy; im_rdata = rd;
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    task automatic do_reset();
        step(1, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0);
    endtask

    // Reset, then run zero-wait until 0x3010 sits in IF/ID (0x3014 in flight).
    task automatic run_to_3010();
        do_reset();
        for (int i = 0; i < 6; i++) step(0, 0, 0, 0, 1, 32'hA000_0000 + 32'(i));
    endtask

    initial begin
        reset = 1; stall = 0; redir_valid = 0; redir_pc = 0; im_ready = 0; im_rdata = 0;
        @(negedge clk);
        step(1, 0, 0, 0, 0, 0);
        chk_en = 1;
        step(1, 0, 0, 0, 0, 0);
        chk("rst_req", 32'(im_req), 32'd0);
        chk("rst_addr", im_addr, RST_PC);
        chk("rst_vld", 32'(if_valid), 32'd0);
        chk("rst_pc", if_pc, 32'd0);
        chk("rst_instr", if_instr, 32'd0);

        // Zero-wait streaming from RESET_PC.
        step(0, 0, 0, 0, 1, 32'h1111_0000);
        chk("first_req", 32'(im_req), 32'd1);
        step(0, 0, 0, 0, 1, 32'h1111_0001);
        chk("seq0_pc", if_pc, 32'h3000);
        chk("seq0_ins", if_instr, 32'h1111_0001);
        step(0, 0, 0, 0, 1, 32'h1111_0002);
        chk("seq1_pc", if_pc, 32'h3004);
        // Stall while 0x3008 is returning.
        step(0, 1, 0, 0, 1, 32'h1111_3008);
        chk("stall_req", 32'(im_req), 32'd0);
        chk("stall_pc", if_pc, 32'h3004);
        step(0, 1, 0, 0, 1, 32'h0);
        step(0, 1, 0, 0, 1, 32'h0);
        chk("stall_hold_pc", if_pc, 32'h3004);
        chk("stall_hold_vld", 32'(if_valid), 32'd1);
        step(0, 0, 0, 0, 1, 32'h1111_300C);
        chk("drain_pc", if_pc, 32'h3008);
        chk("drain_ins", if_instr, 32'h1111_3008);
        step(0, 0, 0, 0, 1, 32'h0);
        chk("after_drain_pc", if_pc, 32'h300C);

        // Memory ready every third cycle.
        for (int i = 0; i < 9; i++) begin
            step(0, 0, 0, 0, (i % 3) == 2, 32'hB000_0000 + 32'(i));
            if ((i % 3) != 2) chk("wait_addr", im_addr, 32'h3010 + 32'(4 * (i / 3)));
            chk("wait_vld", 32'(if_valid), 32'((i % 3) == 2));
        end

        // Redirect with zero-wait memory while 0x3010 is in IF/ID.
        run_to_3010();
        chk("br_at", if_pc, 32'h3010);
        step(0, 0, 1, 32'h3100, 1, 32'hC000_3014);
`ifdef IF_DELAY_SLOT_EN
        chk("ds_slot_pc", if_pc, 32'h3014);
`else
        chk("sq_bubble", 32'(if_valid), 32'd0);
`endif
        chk("br_addr", im_addr, 32'h3100);
        step(0, 0, 0, 0, 1, 32'hC000_3100);
        chk("br_tgt_pc", if_pc, 32'h3100);

        // Same with a 2-wait memory.
        run_to_3010();
        step(0, 0, 1, 32'h3100, 0, 32'h0);
        chk("br2_inflight", im_addr, 32'h3014);
        step(0, 0, 0, 0, 0, 32'h0);
        chk("br2_wait", im_addr, 32'h3014);
        step(0, 0, 0, 0, 1, 32'hC000_3014);
`ifdef IF_DELAY_SLOT_EN
        chk("br2_slot_pc", if_pc, 32'h3014);
`else
        chk("br2_discard", 32'(if_valid), 32'd0);
`endif
        chk("br2_addr", im_addr, 32'h3100);

        // PC wrap at the top of the address space.
        step(0, 0, 1, 32'hFFFF_FFFC, 1, 32'h0);
        step(0, 0, 0, 0, 1, 32'hD000_0000);
        chk("wrap_pc", if_pc, 32'hFFFF_FFFC);
        chk("wrap_addr", im_addr, 32'h0);

        // Reset mid-request, then a stray ready in IDLE.
        step(0, 0, 0, 0, 0, 0);
        step(1, 0, 1, 32'h4000, 0, 0);
        step(0, 0, 0, 0, 1, 32'hEEEE_EEEE);
        chk("late_rdy_vld", 32'(if_valid), 32'd0);
        chk("late_rdy_addr", im_addr, RST_PC);
        step(0, 0, 0, 0, 1, 32'hF000_3000);
        chk("restart_pc", if_pc, RST_PC);

        // Randomized traffic, checked each cycle by the compare process.
        for (int i = 0; i < 4000; i++) begin
            step($urandom_range(0, 99) < 1,
                 $urandom_range(0, 99) < 30,
                 $urandom_range(0, 99) < 10,
                 $urandom & 32'hFFFF_FFFC,
                 $urandom_range(0, 99) < 55,
                 $urandom);
        end

        chk_en = 0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
